// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: access widths, request/response
// records and the responder state encoding.
package MemTypes;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } MemAccessWidth;

  localparam logic [1:0] MEM_WIDTH_ILLEGAL = 2'b11;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        isLoad;
    logic        isStore;
    logic        isUnsigned;
  } MemReq;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } MemResp;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } DmemState;

endpackage

// File: rtl/dmem_lane_aligner.sv
// Byte-lane steering for 32-bit memory words: store mask/replication and
// load extraction with sign/zero extension. Purely combinational.
module dmem_lane_aligner
  import MemTypes::*;
(
  input  logic [1:0]  addrLo,
  input  logic [1:0]  width,
  input  logic        isUnsigned,
  input  logic [31:0] storeData,
  input  logic [31:0] readWord,
  output logic [3:0]  byteMask,
  output logic [31:0] writeWord,
  output logic [31:0] loadData,
  output logic        misalign
);

  logic [31:0] shifted;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    shifted   = readWord >> {addrLo, 3'b000};
    byteMask  = 4'b0000;
    writeWord = storeData;
    loadData  = '0;
    misalign  = 1'b0;
    case (width)
      MEM_BYTE: begin
        byteMask  = 4'b0001 << addrLo;
        writeWord = {4{storeData[7:0]}};
        loadData  = {{24{~isUnsigned & shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        byteMask  = 4'b0011 << addrLo;
        writeWord = {2{storeData[15:0]}};
        loadData  = {{16{~isUnsigned & shifted[15]}}, shifted[15:0]};
        misalign  = addrLo[0];
      end
      MEM_WORD: begin
        byteMask  = 4'b1111;
        writeWord = storeData;
        loadData  = readWord;
        misalign  = (addrLo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency and
// valid/ready handshakes on the request and response channels.
module dmem_responder
  import MemTypes::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_width,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic        req_is_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);
  localparam bit         DIRECT     = (LATENCY == 1);

  DmemState       state;
  logic [3:0]     waitCnt;
  MemReq          reqIn;
  MemReq          heldReq;
  MemReq          curReq;
  MemResp         respReg;
  MemResp         nextResp;
  logic [31:0]    mem [DEPTH_WORDS];

  logic           accept;
  logic           enterResp;
  logic [31:0]    byteOffset;
  logic [IDX_W-1:0] wordIdx;
  logic           outOfRange;
  logic           reqErr;
  logic           doWrite;
  logic [3:0]     laneMask;
  logic [31:0]    laneWord;
  logic [31:0]    laneLoad;
  logic           misalign;

  assign reqIn = '{addr: req_addr, wdata: req_wdata, width: req_width,
                   isLoad: req_is_load, isStore: req_is_store,
                   isUnsigned: req_is_unsigned};

  assign req_ready = (state == DMEM_IDLE);
  assign accept    = req_valid && req_ready;

  // With LATENCY==1 the access happens on the accept edge, so use the live inputs.
  assign curReq     = (state == DMEM_IDLE) ? reqIn : heldReq;
  assign byteOffset = curReq.addr - BASE_ADDR;
  assign wordIdx    = byteOffset[IDX_W+1:2];
  assign outOfRange = (byteOffset >> 2) >= 32'(DEPTH_WORDS);

  assign enterResp = (accept && DIRECT) ||
                     (state == DMEM_WAIT && waitCnt == 4'd1);

  dmem_lane_aligner u_aligner (
    .addrLo     (curReq.addr[1:0]),
    .width      (curReq.width),
    .isUnsigned (curReq.isUnsigned),
    .storeData  (curReq.wdata),
    .readWord   (mem[wordIdx]),
    .byteMask   (laneMask),
    .writeWord  (laneWord),
    .loadData   (laneLoad),
    .misalign   (misalign)
  );

  assign reqErr = misalign || (curReq.width == MEM_WIDTH_ILLEGAL) || outOfRange ||
                  (curReq.isLoad && curReq.isStore);

  assign nextResp.err   = reqErr;
  assign nextResp.rdata = (!reqErr && curReq.isLoad) ? laneLoad : '0;
  assign doWrite        = enterResp && !reqErr && curReq.isStore && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DMEM_IDLE;
      waitCnt <= 4'd0;
      respReg <= '0;
    end else begin
      case (state)
        DMEM_IDLE: if (accept) begin
          waitCnt <= LOAD_COUNT;
          state   <= DIRECT ? DMEM_RESP : DMEM_WAIT;
        end
        DMEM_WAIT: begin
          waitCnt <= waitCnt - 4'd1;
          if (waitCnt == 4'd1) state <= DMEM_RESP;
        end
        DMEM_RESP: if (resp_ready) state <= DMEM_IDLE;
        default:   state <= DMEM_IDLE;
      endcase
      if (enterResp) respReg <= nextResp;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) heldReq <= reqIn;
  end

  // NOTE: the backing array has no reset; clearing thousands of words is not wanted.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (laneMask[i]) mem[wordIdx][8*i +: 8] <= laneWord[8*i +: 8];
      end
    end
  end

  assign resp_valid = (state == DMEM_RESP);
  assign resp_rdata = respReg.rdata;
  assign resp_err   = respReg.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance at LATENCY=1 (base 0) and
// one at LATENCY=3 (base 0x100), driven with hand-computed directed vectors.
module tb_dmem_responder;
  import MemTypes::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE3 = 32'h0000_0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3;
  MemReq       req1, req3;
  logic        valid1, valid3, ready1, ready3;
  logic        rv1, rv3, rr1, rr3, err1, err3;
  logic [31:0] rd1, rd3;

  MemResp q1[$];
  MemResp q3[$];
  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(32'h0)) u1 (
    .clk(clk), .rst(rst1), .req_valid(valid1), .req_ready(ready1),
    .req_addr(req1.addr), .req_wdata(req1.wdata), .req_width(req1.width),
    .req_is_load(req1.isLoad), .req_is_store(req1.isStore),
    .req_is_unsigned(req1.isUnsigned), .resp_valid(rv1), .resp_ready(rr1),
    .resp_rdata(rd1), .resp_err(err1)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .BASE_ADDR(BASE3)) u3 (
    .clk(clk), .rst(rst3), .req_valid(valid3), .req_ready(ready3),
    .req_addr(req3.addr), .req_wdata(req3.wdata), .req_width(req3.width),
    .req_is_load(req3.isLoad), .req_is_store(req3.isStore),
    .req_is_unsigned(req3.isUnsigned), .resp_valid(rv3), .resp_ready(rr3),
    .resp_rdata(rd3), .resp_err(err3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic MemReq mk(input logic [31:0] a, input logic [31:0] wd,
                               input logic [1:0] w, input logic ld,
                               input logic st, input logic us);
    return '{addr: a, wdata: wd, width: w, isLoad: ld, isStore: st, isUnsigned: us};
  endfunction

  task automatic drive(input int sel, input MemReq r, input logic v);
    if (sel == 1) begin req1 = r; valid1 = v; end
    else          begin req3 = r; valid3 = v; end
  endtask

  task automatic setRespReady(input int sel, input logic v);
    if (sel == 1) rr1 = v; else rr3 = v;
  endtask

  function automatic logic reqReady(input int sel);
    return (sel == 1) ? ready1 : ready3;
  endfunction

  function automatic logic respValid(input int sel);
    return (sel == 1) ? rv1 : rv3;
  endfunction

  // Issue one request, queue its expected response, measure latency, and
  // optionally hold resp_ready low for 'stall' cycles while checking stability.
  task automatic doReq(input int sel, input string tag, input MemReq r,
                       input logic [31:0] expData, input logic expErr, input int stall);
    int n;
    int lat;
    MemResp e;
    e.rdata = expData;
    e.err   = expErr;
    @(negedge clk);
    drive(sel, r, 1'b1);
    n = 0;
    while (!reqReady(sel) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL %s: accept timeout", tag);
      drive(sel, r, 1'b0);
      return;
    end
    if (sel == 1) q1.push_back(e); else q3.push_back(e);
    if (stall > 0) setRespReady(sel, 1'b0);
    @(posedge clk);
    #1 drive(sel, mk(32'hFFFF_FFFC, $urandom, 2'b10, 1'b0, 1'b1, 1'b1), 1'b0);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!respValid(sel) && lat < 100);
    check({tag, " latency"}, 32'(lat), (sel == 1) ? 32'd1 : 32'd3);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, " stall valid"}, 32'(respValid(sel)), 32'd1);
      check({tag, " stall rdata"}, (sel == 1) ? rd1 : rd3, expData);
      check({tag, " stall err"}, 32'((sel == 1) ? err1 : err3), 32'(expErr));
      check({tag, " stall req_ready"}, 32'(reqReady(sel)), 32'd0);
    end
    if (stall > 0) setRespReady(sel, 1'b1);
    @(posedge clk); #1;
    check({tag, " back to idle"}, 32'(reqReady(sel)), 32'd1);
  endtask

  // Scoreboard monitors: pop and compare on every response handshake.
  always @(negedge clk) begin
    if (rv1 && rr1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected response: rdata=%h err=%b", rd1, err1);
      end else begin
        MemResp e;
        e = q1.pop_front();
        check("dut1 rdata", rd1, e.rdata);
        check("dut1 err", 32'(err1), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (rv3 && rr3) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut3 unexpected response: rdata=%h err=%b", rd3, err3);
      end else begin
        MemResp e;
        e = q3.pop_front();
        check("dut3 rdata", rd3, e.rdata);
        check("dut3 err", 32'(err3), 32'(e.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst1 = 1'b1; rst3 = 1'b1;
    rr1 = 1'b1;  rr3 = 1'b1;
    drive(1, mk(32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0), 1'b0);
    drive(3, mk(32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset resp_valid", 32'(rv1), 32'd0);
    check("reset resp_rdata", rd1, 32'h0);
    check("reset resp_err", 32'(err1), 32'd0);
    check("reset req_ready", 32'(ready1), 32'd1);
    check("reset dut3 resp_valid", 32'(rv3), 32'd0);
    check("reset dut3 req_ready", 32'(ready3), 32'd1);
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;

    // LATENCY=1, base 0
    doReq(1, "st w 0x10",     mk(32'h10, 32'hDEADBEEF, MEM_WORD, 1'b0, 1'b1, 1'b0), 32'h0, 1'b0, 0);
    doReq(1, "ld w 0x10",     mk(32'h10, 32'h0,        MEM_WORD, 1'b1, 1'b0, 1'b0), 32'hDEADBEEF, 1'b0, 0);
    doReq(1, "st b 0x13",     mk(32'h13, 32'h00000080, MEM_BYTE, 1'b0, 1'b1, 1'b0), 32'h0, 1'b0, 0);
    doReq(1, "ld sb 0x13",    mk(32'h13, 32'h0,        MEM_BYTE, 1'b1, 1'b0, 1'b0), 32'hFFFFFF80, 1'b0, 0);
    doReq(1, "ld ub 0x13",    mk(32'h13, 32'h0,        MEM_BYTE, 1'b1, 1'b0, 1'b1), 32'h00000080, 1'b0, 0);
    doReq(1, "ld w 0x10 b",   mk(32'h10, 32'h0,        MEM_WORD, 1'b1, 1'b0, 1'b0), 32'h80ADBEEF, 1'b0, 0);
    doReq(1, "ld uw 0x10",    mk(32'h10, 32'h0,        MEM_WORD, 1'b1, 1'b0, 1'b1), 32'h80ADBEEF, 1'b0, 0);
    doReq(1, "ld h 0x11 mis", mk(32'h11, 32'h0,        MEM_HALF, 1'b1, 1'b0, 1'b0), 32'h0, 1'b1, 0);
    doReq(1, "st w 0x12 mis", mk(32'h12, 32'hCAFEF00D, MEM_WORD, 1'b0, 1'b1, 1'b0), 32'h0, 1'b1, 0);
    doReq(1, "ld w 0x10 c",   mk(32'h10, 32'h0,        MEM_WORD, 1'b1, 1'b0, 1'b0), 32'h80ADBEEF, 1'b0, 0);
    doReq(1, "ld w oor",      mk(32'h400, 32'h0,       MEM_WORD, 1'b1, 1'b0, 1'b0), 32'h0, 1'b1, 0);
    doReq(1, "st w last",     mk(32'h3FC, 32'h0BADCAFE, MEM_WORD, 1'b0, 1'b1, 1'b0), 32'h0, 1'b0, 0);
    doReq(1, "ld w last",     mk(32'h3FC, 32'h0,       MEM_WORD, 1'b1, 1'b0, 1'b0), 32'h0BADCAFE, 1'b0, 0);
    doReq(1, "st w 0x20",     mk(32'h20, 32'h11223344, MEM_WORD, 1'b0, 1'b1, 1'b0), 32'h0, 1'b0, 0);
    doReq(1, "st h 0x22",     mk(32'h22, 32'hFFFFF00D, MEM_HALF, 1'b0, 1'b1, 1'b0), 32'h0, 1'b0, 0);
    doReq(1, "ld uh 0x22",    mk(32'h22, 32'h0,        MEM_HALF, 1'b1, 1'b0, 1'b1), 32'h0000F00D, 1'b0, 0);
    doReq(1, "ld sh 0x22",    mk(32'h22, 32'h0,        MEM_HALF, 1'b1, 1'b0, 1'b0), 32'hFFFFF00D, 1'b0, 0);
    doReq(1, "ld w 0x20",     mk(32'h20, 32'h0,        MEM_WORD, 1'b1, 1'b0, 1'b0), 32'hF00D3344, 1'b0, 0);
    doReq(1, "ld+st 0x20",    mk(32'h20, 32'h0,        MEM_WORD, 1'b1, 1'b1, 1'b0), 32'h0, 1'b1, 0);
    doReq(1, "ld w 0x20 b",   mk(32'h20, 32'h0,        MEM_WORD, 1'b1, 1'b0, 1'b0), 32'hF00D3344, 1'b0, 0);
    doReq(1, "width 11",      mk(32'h20, 32'h0,        2'b11,    1'b1, 1'b0, 1'b0), 32'h0, 1'b1, 0);
    doReq(1, "no-op",         mk(32'h20, 32'h0,        MEM_WORD, 1'b0, 1'b0, 1'b0), 32'h0, 1'b0, 0);
    doReq(1, "ld sb 0x21",    mk(32'h21, 32'h0,        MEM_BYTE, 1'b1, 1'b0, 1'b0), 32'h00000033, 1'b0, 0);
    doReq(1, "ld sb 0x23",    mk(32'h23, 32'h0,        MEM_BYTE, 1'b1, 1'b0, 1'b0), 32'hFFFFFFF0, 1'b0, 0);
    doReq(1, "ld sh 0x20",    mk(32'h20, 32'h0,        MEM_HALF, 1'b1, 1'b0, 1'b0), 32'h00003344, 1'b0, 0);

    // LATENCY=3, base 0x100
    doReq(3, "d3 st w 0x120", mk(32'h120, 32'hA5A5A5A5, MEM_WORD, 1'b0, 1'b1, 1'b0), 32'h0, 1'b0, 0);
    doReq(3, "d3 ld stall",   mk(32'h120, 32'h0,        MEM_WORD, 1'b1, 1'b0, 1'b0), 32'hA5A5A5A5, 1'b0, 5);

    // Store dropped by a reset while waiting
    @(negedge clk);
    drive(3, mk(32'h120, 32'h12345678, MEM_WORD, 1'b0, 1'b1, 1'b0), 1'b1);
    n = 0;
    while (!ready3 && n < 100) begin @(negedge clk); n++; end
    check("d3 rst accept ready", 32'(ready3), 32'd1);
    @(posedge clk);
    #1 drive(3, mk(32'h0, 32'h0, MEM_BYTE, 1'b0, 1'b0, 1'b0), 1'b0);
    @(negedge clk);
    check("d3 in wait req_ready", 32'(ready3), 32'd0);
    rst3 = 1'b1;
    @(posedge clk); #1;
    check("d3 rst resp_valid", 32'(rv3), 32'd0);
    check("d3 rst req_ready", 32'(ready3), 32'd1);
    @(negedge clk);
    rst3 = 1'b0;
    repeat (4) @(negedge clk);
    check("d3 no resp after rst", 32'(rv3), 32'd0);

    doReq(3, "d3 ld after rst", mk(32'h120, 32'h0, MEM_WORD, 1'b1, 1'b0, 1'b0), 32'hA5A5A5A5, 1'b0, 0);
    doReq(3, "d3 underflow",    mk(32'h0FC, 32'h0, MEM_WORD, 1'b1, 1'b0, 1'b0), 32'h0, 1'b1, 0);
    doReq(3, "d3 oor",          mk(32'h500, 32'h0, MEM_WORD, 1'b1, 1'b0, 1'b0), 32'h0, 1'b1, 0);
    doReq(3, "d3 ld ub 0x121",  mk(32'h121, 32'h0, MEM_BYTE, 1'b1, 1'b0, 1'b1), 32'h000000A5, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("dut1 pending responses", 32'(q1.size()), 32'd0);
    check("dut3 pending responses", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the memory-access stage. It accepts one load or store request at a time: address from the ALU result, store data, a 2-bit access width, and load/store/unsigned flags.
- After a configurable latency it returns a response, carrying either load data (byte-lane extracted, sign- or zero-extended) or a store acknowledge.
- Valid/ready handshake on both request and response channels, so the pipeline can stall on memory.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the backing array; power of two.
- LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_width  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_is_load  input  1  load request.
- req_is_store  input  1  store request.
- req_is_unsigned  input  1  zero-extend load result.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer takes response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range, illegal width, or both flags set.

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset enters IDLE. Reset values: resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
- req_ready = (state==IDLE). It is combinational from state only and never depends on req_valid.
- Accept occurs when req_valid && req_ready. The request is latched into internal registers and the counter is loaded with LATENCY-1.
  - LATENCY==1: go directly to RESP.
  - Otherwise: go to WAIT.
- WAIT: counter decrements each cycle; at 1 the next edge enters RESP. resp_valid rises exactly LATENCY cycles after the accept edge.
- Entry edge into RESP performs the access.
  - Store: byte-masked write (mask 0001<<a[1:0], 0011<<a[1:0], or 1111), data replicated to lanes.
  - Load: read word, select lane by addr[1:0], extend per width and unsigned flag. Word loads ignore the unsigned flag.
- RESP: hold resp_valid, resp_rdata and resp_err stable until resp_ready. On the resp_valid && resp_ready edge, return to IDLE. There is no same-cycle new accept; back-to-back throughput is one request per LATENCY+1 cycles minimum.
- Error cases: half with a[0]=1; word with a[1:0]!=0; width 11; word index >= DEPTH_WORDS (computed as (addr-BASE_ADDR)>>2, including underflow); is_load && is_store.
  - Error response: resp_err=1, resp_rdata=0, no array write.
  - Error requests still follow normal latency and handshake.
- Neither flag set: accepted as a no-op; resp_err=0, resp_rdata=0.
- Store response: resp_rdata=0, resp_err=0 when legal.
- Array contents are not reset. Reads of never-written words return the array's current contents (X in simulation is acceptable).
- Reset mid-operation (WAIT or RESP): pending request dropped, resp_valid=0 next cycle.
  - A store in WAIT is never committed.
  - A store already committed on RESP entry stays committed.
- req_* inputs are don't-care when not accepting. Changing them in WAIT/RESP has no effect.

Decomposition:
- Package MemTypes:
  - MemAccessWidth enum (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10).
  - MemReq packed struct (addr, wdata, width, isLoad, isStore, isUnsigned).
  - MemResp packed struct (rdata, err).
  - DmemState enum.
- Sub-module dmem_lane_aligner (combinational), shared with the pipeline's future load path:
  - Inputs: addr[1:0], width, unsigned flag, store data, read word.
  - Outputs: byte mask, replicated write word, extended load data, misalign flag.

Test Plan:
- LATENCY=1: store word 0xDEADBEEF @0x10, then load word @0x10 -> resp_valid one cycle after each accept; load rdata=0xDEADBEEF, err=0.
- Store byte 0x80 @0x13, load signed byte @0x13 -> 0xFFFFFF80. Load unsigned byte -> 0x00000080. Load word @0x10 -> 0x80ADBEEF.
- Load half @0x11 -> err=1, rdata=0. Store word @0x12 -> err=1; subsequent word load @0x10 unchanged. Addr=DEPTH_WORDS*4 -> err=1.
- LATENCY=3, resp_ready held 0 for 5 cycles: resp_valid asserts 3 cycles after accept; rdata/err stable; req_ready=0 throughout; returns to IDLE only on the ready edge.
- Store 0x12345678 @0x20, assert rst during WAIT (LATENCY=3), then load @0x20 -> old contents (not 0x12345678); resp_valid=0 the cycle after reset.
- Load half unsigned 0xF00D stored at @0x22 -> 0x0000F00D; load signed -> 0xFFFFF00D. is_load&&is_store set -> err=1, no write.
